// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALUOp encodings and the control bundle for the pipelined control unit.
package ctrl_pkg;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned ALUOP_BASE = 2;

  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [ALUOP_BASE-1:0] ALUOP_ADD = 2'b00;
  localparam logic [ALUOP_BASE-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_BASE-1:0] ALUOP_R   = 2'b10;
  localparam logic [ALUOP_BASE-1:0] ALUOP_I   = 2'b11;

  // Control bundle decoded in ID and carried down the pipe; all-zero is a bubble.
  typedef struct packed {
    logic [ALUOP_BASE-1:0] alu_op;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  store;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode decoder: control bundle plus rs1/rs2 operand-use flags.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [OP_W-1:0] op_i,
  output ctrl_bundle_t    ctrl_c_o,
  output logic            rs1_use_c_o,
  output logic            rs2_use_c_o
);

  // Opcode to control bundle; anything unrecognised is illegal with every enable low.
  always_comb begin
    ctrl_c_o    = '0;
    rs1_use_c_o = 1'b0;
    rs2_use_c_o = 1'b0;
    unique case (op_i)
      OP_RTYPE: begin
        ctrl_c_o.alu_op    = ALUOP_R;
        ctrl_c_o.reg_write = 1'b1;
        rs1_use_c_o        = 1'b1;
        rs2_use_c_o        = 1'b1;
      end
      OP_IALU: begin
        ctrl_c_o.alu_op    = ALUOP_I;
        ctrl_c_o.alu_src   = 1'b1;
        ctrl_c_o.reg_write = 1'b1;
        rs1_use_c_o        = 1'b1;
      end
      OP_LOAD: begin
        ctrl_c_o.alu_op     = ALUOP_ADD;
        ctrl_c_o.alu_src    = 1'b1;
        ctrl_c_o.mem_read   = 1'b1;
        ctrl_c_o.mem_to_reg = 1'b1;
        ctrl_c_o.reg_write  = 1'b1;
        rs1_use_c_o         = 1'b1;
      end
      OP_STORE: begin
        ctrl_c_o.alu_op    = ALUOP_ADD;
        ctrl_c_o.alu_src   = 1'b1;
        ctrl_c_o.mem_write = 1'b1;
        ctrl_c_o.store     = 1'b1;
        rs1_use_c_o        = 1'b1;
        rs2_use_c_o        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_c_o.alu_op = ALUOP_BR;
        ctrl_c_o.branch = 1'b1;
        rs1_use_c_o     = 1'b1;
        rs2_use_c_o     = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        if (EXT_OPS != 0) begin
          ctrl_c_o.alu_op    = ALUOP_ADD;
          ctrl_c_o.alu_src   = 1'b1;
          ctrl_c_o.reg_write = 1'b1;
          ctrl_c_o.jump      = 1'b1;
          rs1_use_c_o        = (op_i == OP_JALR);
        end else begin
          ctrl_c_o.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT_OPS != 0) begin
          ctrl_c_o.alu_op    = ALUOP_I;
          ctrl_c_o.alu_src   = 1'b1;
          ctrl_c_o.reg_write = 1'b1;
        end else begin
          ctrl_c_o.illegal = 1'b1;
        end
      end
      default: ctrl_c_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Main control for the 5-stage RV32 pipe: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall with bubble insertion and branch-resolution flush.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned EXT_OPS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [6:0]            op_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic [ALUOP_W-1:0]    ex_alu_op_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_store_o,
  output logic                  wb_reg_write_o,
  output logic                  wb_mem_to_reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  illegal_o
);

  ctrl_bundle_t          dec_ctrl;
  logic                  rs1_use;
  logic                  rs2_use;
  logic                  load_use;
  logic                  stall_c;

  ctrl_bundle_t          idex_q, idex_d;
  logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d;

  logic                  exmem_mem_read_q, exmem_mem_write_q, exmem_store_q;
  logic                  exmem_reg_write_q, exmem_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] exmem_rd_q;

  logic                  memwb_reg_write_q, memwb_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] memwb_rd_q;

  ctrl_decoder #(
    .EXT_OPS (EXT_OPS)
  ) u_dec (
    .op_i        (op_i),
    .ctrl_c_o    (dec_ctrl),
    .rs1_use_c_o (rs1_use),
    .rs2_use_c_o (rs2_use)
  );

  // Load-use hazard: the load now in EX targets a register the ID instruction reads.
  always_comb begin
    load_use = idex_q.mem_read && (idex_rd_q != '0) &&
               ((rs1_use && (rs1_i == idex_rd_q)) ||
                (rs2_use && (rs2_i == idex_rd_q)));
    stall_c  = load_use && !flush_i;
  end

  // ID/EX next state: decoded bundle, or a bubble when flushed or stalled.
  always_comb begin
    idex_d    = dec_ctrl;
    idex_rd_d = rd_i;
    if (flush_i || stall_c) begin
      idex_d    = '0;
      idex_rd_d = '0;
    end
  end

  // Stage registers; every stage advances each cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q             <= '0;
      idex_rd_q          <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_store_q      <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_rd_q         <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_rd_q         <= '0;
    end else begin
      idex_q             <= idex_d;
      idex_rd_q          <= idex_rd_d;
      exmem_mem_read_q   <= idex_q.mem_read;
      exmem_mem_write_q  <= idex_q.mem_write;
      exmem_store_q      <= idex_q.store;
      exmem_reg_write_q  <= idex_q.reg_write;
      exmem_mem_to_reg_q <= idex_q.mem_to_reg;
      exmem_rd_q         <= idex_rd_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_rd_q         <= exmem_rd_q;
    end
  end

  assign stall_o         = stall_c;
  assign pc_write_o      = !stall_c;
  assign ifid_write_o    = !stall_c;
  assign ex_alu_op_o     = ALUOP_W'(idex_q.alu_op);
  assign ex_alu_src_o    = idex_q.alu_src;
  assign ex_branch_o     = idex_q.branch;
  assign ex_jump_o       = idex_q.jump;
  assign illegal_o       = idex_q.illegal;
  assign mem_read_o      = exmem_mem_read_q;
  assign mem_write_o     = exmem_mem_write_q;
  assign mem_store_o     = exmem_store_q;
  assign wb_reg_write_o  = memwb_reg_write_q;
  assign wb_mem_to_reg_o = memwb_mem_to_reg_q;
  assign wb_rd_o         = memwb_rd_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (extended ops on/off) driven in lockstep
// and checked against a history-based reference model.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       flush = 1'b0;

  logic       stall_a, pcw_a, ifid_a, src_a, br_a, jp_a, mr_a, mw_a, st_a, rw_a, m2r_a, ill_a;
  logic [1:0] aluop_a;
  logic [4:0] wbrd_a;
  logic       stall_b, pcw_b, ifid_b, src_b, br_b, jp_b, mr_b, mw_b, st_b, rw_b, m2r_b, ill_b;
  logic [1:0] aluop_b;
  logic [4:0] wbrd_b;

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EXT_OPS(1)) u_dut_ext (
    .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .flush_i(flush), .stall_o(stall_a), .pc_write_o(pcw_a), .ifid_write_o(ifid_a),
    .ex_alu_op_o(aluop_a), .ex_alu_src_o(src_a), .ex_branch_o(br_a), .ex_jump_o(jp_a),
    .mem_read_o(mr_a), .mem_write_o(mw_a), .mem_store_o(st_a), .wb_reg_write_o(rw_a),
    .wb_mem_to_reg_o(m2r_a), .wb_rd_o(wbrd_a), .illegal_o(ill_a));

  pipelined_control_unit #(.REG_ADDR_W(5), .ALUOP_W(2), .EXT_OPS(0)) u_dut_base (
    .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .flush_i(flush), .stall_o(stall_b), .pc_write_o(pcw_b), .ifid_write_o(ifid_b),
    .ex_alu_op_o(aluop_b), .ex_alu_src_o(src_b), .ex_branch_o(br_b), .ex_jump_o(jp_b),
    .mem_read_o(mr_b), .mem_write_o(mw_b), .mem_store_o(st_b), .wb_reg_write_o(rw_b),
    .wb_mem_to_reg_o(m2r_b), .wb_rd_o(wbrd_b), .illegal_o(ill_b));

  // Observed stage outputs packed in a fixed order for whole-pipe comparison.
  logic [10:0] obs_a, obs_b;
  assign obs_a = {aluop_a, src_a, br_a, jp_a, ill_a, mr_a, mw_a, st_a, rw_a, m2r_a};
  assign obs_b = {aluop_b, src_b, br_b, jp_b, ill_b, mr_b, mw_b, st_b, rw_b, m2r_b};

  typedef struct packed {
    logic [1:0] aluop;
    logic src, rw, m2r, mr, mw, st, br, jp, ill;
    logic [4:0] rd;
  } ent_t;

  // Model history: index 0 = instruction now in EX, 1 = MEM, 2 = WB.
  ent_t qa [3];
  ent_t qb [3];
  int   errors = 0;
  int   checks = 0;
  logic exp_st_a, exp_st_b, obs_st_a, obs_st_b, obs_pcw_a, obs_pcw_b, obs_ifid_a, obs_ifid_b;

  localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

  function automatic ent_t dec(input logic [6:0] o, input logic [4:0] d, input bit ext);
    ent_t e = '0;
    e.rd = d;
    case (o)
      R:   begin e.aluop = 2'b10; e.rw = 1'b1; end
      IA:  begin e.aluop = 2'b11; e.src = 1'b1; e.rw = 1'b1; end
      LW:  begin e.src = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; end
      SW:  begin e.src = 1'b1; e.mw = 1'b1; e.st = 1'b1; end
      BEQ: begin e.aluop = 2'b01; e.br = 1'b1; end
      JAL, JALR: if (ext) begin e.rw = 1'b1; e.jp = 1'b1; e.src = 1'b1; end else e.ill = 1'b1;
      LUI: if (ext) begin e.aluop = 2'b11; e.src = 1'b1; e.rw = 1'b1; end else e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.rd = '0;
    return e;
  endfunction

  function automatic bit hazard(input ent_t ex, input logic [6:0] o, input logic [4:0] a,
                                input logic [4:0] b, input logic fl, input bit ext);
    bit u1 = (o == R) || (o == IA) || (o == LW) || (o == SW) || (o == BEQ) || (ext && o == JALR);
    bit u2 = (o == R) || (o == SW) || (o == BEQ);
    return !fl && ex.mr && (ex.rd != 0) && ((u1 && a == ex.rd) || (u2 && b == ex.rd));
  endfunction

  function automatic logic [10:0] pack_exp(input ent_t ex, input ent_t me, input ent_t wb);
    return {ex.aluop, ex.src, ex.br, ex.jp, ex.ill, me.mr, me.mw, me.st, wb.rw, wb.m2r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin qa[i] = '0; qb[i] = '0; end
  endtask

  // Drive one ID instruction, sample the combinational stall, advance one clock.
  task automatic issue(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic fl);
    ent_t na, nb;
    op = o; rs1 = a; rs2 = b; rd = d; flush = fl;
    #1;
    exp_st_a = hazard(qa[0], o, a, b, fl, 1'b1);
    exp_st_b = hazard(qb[0], o, a, b, fl, 1'b0);
    obs_st_a = stall_a; obs_pcw_a = pcw_a; obs_ifid_a = ifid_a;
    obs_st_b = stall_b; obs_pcw_b = pcw_b; obs_ifid_b = ifid_b;
    na = (fl || exp_st_a) ? ent_t'('0) : dec(o, d, 1'b1);
    nb = (fl || exp_st_b) ? ent_t'('0) : dec(o, d, 1'b0);
    @(posedge clk);
    qa[2] = qa[1]; qa[1] = qa[0]; qa[0] = na;
    qb[2] = qb[1]; qb[1] = qb[0]; qb[0] = nb;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(7'h00, 5'd0, 5'd0, 5'd0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (obs_a !== 11'd0 || wbrd_a !== 5'd0) begin errors++; $display("FAIL reset_outs_ext got=%b/%0d exp=0", obs_a, wbrd_a); end
    checks++; if (obs_b !== 11'd0 || wbrd_b !== 5'd0) begin errors++; $display("FAIL reset_outs_base got=%b/%0d exp=0", obs_b, wbrd_b); end
    checks++; if ({stall_a, pcw_a, ifid_a} !== 3'b011) begin errors++; $display("FAIL reset_stall got=%b exp=011", {stall_a, pcw_a, ifid_a}); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rtype();
    issue(R, 5'd1, 5'd2, 5'd3, 1'b0);
    checks++; if (obs_st_a !== 1'b0) begin errors++; $display("FAIL rtype_stall got=%b exp=0", obs_st_a); end
    checks++; if (aluop_a !== 2'b10) begin errors++; $display("FAIL rtype_ex_aluop got=%b exp=10", aluop_a); end
    nop();
    checks++; if (obs_st_a !== 1'b0) begin errors++; $display("FAIL rtype_stall2 got=%b exp=0", obs_st_a); end
    nop();
    checks++; if (rw_a !== 1'b1 || wbrd_a !== 5'd3) begin errors++; $display("FAIL rtype_wb got=%b/%0d exp=1/3", rw_a, wbrd_a); end
  endtask

  task automatic test_load_use();
    issue(LW, 5'd1, 5'd0, 5'd5, 1'b0);
    issue(R, 5'd5, 5'd2, 5'd6, 1'b0);
    checks++; if (obs_st_a !== 1'b1 || obs_pcw_a !== 1'b0 || obs_ifid_a !== 1'b0) begin
      errors++; $display("FAIL lu_stall got=%b%b%b exp=100", obs_st_a, obs_pcw_a, obs_ifid_a); end
    checks++; if (aluop_a !== 2'b00 || mr_a !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b/%b exp=00/1", aluop_a, mr_a); end
    issue(R, 5'd5, 5'd2, 5'd6, 1'b0);
    checks++; if (obs_st_a !== 1'b0) begin errors++; $display("FAIL lu_one_bubble got=%b exp=0", obs_st_a); end
    checks++; if (aluop_a !== 2'b10 || mr_a !== 1'b0) begin errors++; $display("FAIL lu_late_add got=%b/%b exp=10/0", aluop_a, mr_a); end
    issue(LW, 5'd1, 5'd0, 5'd0, 1'b0);
    issue(R, 5'd0, 5'd0, 5'd6, 1'b0);
    checks++; if (obs_st_a !== 1'b0) begin errors++; $display("FAIL lu_x0 got=%b exp=0", obs_st_a); end
    issue(LW, 5'd1, 5'd0, 5'd5, 1'b0);
    issue(SW, 5'd3, 5'd5, 5'd0, 1'b0);
    checks++; if (obs_st_a !== 1'b1) begin errors++; $display("FAIL lu_sw got=%b exp=1", obs_st_a); end
    issue(SW, 5'd3, 5'd5, 5'd0, 1'b0);
    checks++; if (obs_st_a !== 1'b0) begin errors++; $display("FAIL lu_sw_once got=%b exp=0", obs_st_a); end
  endtask

  task automatic test_flush();
    issue(LW, 5'd1, 5'd0, 5'd5, 1'b0);
    issue(BEQ, 5'd5, 5'd0, 5'd0, 1'b1);
    checks++; if (obs_st_a !== 1'b0 || obs_pcw_a !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b/%b exp=0/1", obs_st_a, obs_pcw_a); end
    checks++; if (br_a !== 1'b0 || aluop_a !== 2'b00) begin errors++; $display("FAIL flush_ex got=%b/%b exp=0/00", br_a, aluop_a); end
    nop();
    checks++; if (mw_a !== 1'b0 || rw_a !== 1'b1) begin errors++; $display("FAIL flush_mem got=%b/%b exp=0/1", mw_a, rw_a); end
    nop();
    checks++; if (rw_a !== 1'b0) begin errors++; $display("FAIL flush_wb got=%b exp=0", rw_a); end
  endtask

  task automatic test_ext_ops();
    issue(JAL, 5'd0, 5'd0, 5'd7, 1'b0);
    checks++; if (jp_a !== 1'b1 || ill_a !== 1'b0) begin errors++; $display("FAIL jal_ext_ex got=%b/%b exp=1/0", jp_a, ill_a); end
    checks++; if (ill_b !== 1'b1 || jp_b !== 1'b0) begin errors++; $display("FAIL jal_base_ex got=%b/%b exp=1/0", ill_b, jp_b); end
    nop();
    checks++; if (ill_b !== 1'b0 || mw_b !== 1'b0 || mr_b !== 1'b0) begin errors++; $display("FAIL jal_base_mem got=%b%b%b exp=000", ill_b, mw_b, mr_b); end
    nop();
    checks++; if (rw_a !== 1'b1 || wbrd_a !== 5'd7) begin errors++; $display("FAIL jal_ext_wb got=%b/%0d exp=1/7", rw_a, wbrd_a); end
    checks++; if (rw_b !== 1'b0) begin errors++; $display("FAIL jal_base_wb got=%b exp=0", rw_b); end
  endtask

  task automatic test_mid_reset();
    issue(SW, 5'd1, 5'd2, 5'd0, 1'b0);
    nop();
    checks++; if (mw_a !== 1'b1 || st_a !== 1'b1) begin errors++; $display("FAIL mr_sw_mem got=%b/%b exp=1/1", mw_a, st_a); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mw_a !== 1'b0 || obs_a !== 11'd0) begin errors++; $display("FAIL mr_async_ext got=%b/%b exp=0", mw_a, obs_a); end
    checks++; if (obs_b !== 11'd0) begin errors++; $display("FAIL mr_async_base got=%b exp=0", obs_b); end
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      nop();
      checks++; if (obs_a !== 11'd0 || obs_st_a !== 1'b0) begin errors++; $display("FAIL mr_idle_%0d got=%b/%b exp=0", i, obs_a, obs_st_a); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{R, IA, LW, SW, BEQ, JAL, JALR, LUI, LW};
    logic [6:0] o;
    for (int n = 0; n < 400; n++) begin
      int k = $urandom_range(0, 9);
      if (k == 9) o = 7'($urandom); else o = ops[k];
      issue(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      checks++; if (obs_st_a !== exp_st_a || obs_pcw_a !== !exp_st_a || obs_ifid_a !== !exp_st_a) begin
        errors++; $display("FAIL rnd_stall_ext n=%0d got=%b%b%b exp_stall=%b", n, obs_st_a, obs_pcw_a, obs_ifid_a, exp_st_a); end
      checks++; if (obs_st_b !== exp_st_b || obs_pcw_b !== !exp_st_b || obs_ifid_b !== !exp_st_b) begin
        errors++; $display("FAIL rnd_stall_base n=%0d got=%b%b%b exp_stall=%b", n, obs_st_b, obs_pcw_b, obs_ifid_b, exp_st_b); end
      checks++; if (obs_a !== pack_exp(qa[0], qa[1], qa[2])) begin
        errors++; $display("FAIL rnd_pipe_ext n=%0d got=%b exp=%b", n, obs_a, pack_exp(qa[0], qa[1], qa[2])); end
      checks++; if (obs_b !== pack_exp(qb[0], qb[1], qb[2])) begin
        errors++; $display("FAIL rnd_pipe_base n=%0d got=%b exp=%b", n, obs_b, pack_exp(qb[0], qb[1], qb[2])); end
      if (qa[2].rw) begin
        checks++; if (wbrd_a !== qa[2].rd) begin errors++; $display("FAIL rnd_wbrd_ext n=%0d got=%0d exp=%0d", n, wbrd_a, qa[2].rd); end
      end
      if (qb[2].rw) begin
        checks++; if (wbrd_b !== qb[2].rd) begin errors++; $display("FAIL rnd_wbrd_base n=%0d got=%0d exp=%0d", n, wbrd_b, qb[2].rd); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rtype();
    test_load_use();
    test_flush();
    test_ext_ops();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
